// File: rtl/pickup_tracker_pkg.sv
// +----------------------------------------------------------------------+
// | pickup_tracker_pkg: map tile codes, pickup points, lookup FSM states |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package pickup_tracker_pkg;

    localparam logic [3:0] empty_tile  = 4'h0;
    localparam logic [3:0] candy_tile  = 4'h1;
    localparam logic [3:0] cookie_tile = 4'h2;

    localparam int CANDY_POINTS  = 10;
    localparam int COOKIE_POINTS = 50;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        EAT  = 2'd2
    } pickup_state_t;

endpackage

`default_nettype wire

// File: rtl/pickup_tracker_power_timer.sv
// +----------------------------------------------------------------------+
// | power_timer: frame-based power-mode countdown with warn/end outputs  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module power_timer #(
    parameter int POWER_FRAMES = 360,
    parameter int WARN_FRAMES  = 120
) (
    input  logic vga_pix_clk,
    input  logic rst,
    input  logic clear,
    input  logic reload,
    input  logic frame_stb,
    output logic active,
    output logic warn,
    output logic end_stb
);

    localparam int T_W = $clog2(POWER_FRAMES + 1);

    logic [T_W-1:0] timer_q, timer_d;
    logic           end_stb_q, end_stb_d;

    // Clear beats reload beats countdown; a reload never produces an end pulse.
    always_comb begin
        timer_d   = timer_q;
        end_stb_d = 1'b0;
        if (clear) begin
            timer_d = '0;
        end else if (reload) begin
            timer_d = T_W'(POWER_FRAMES);
        end else if (frame_stb && (timer_q != '0)) begin
            timer_d   = timer_q - T_W'(1);
            end_stb_d = (timer_q == T_W'(1));
        end
    end

    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            timer_q   <= '0;
            end_stb_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            end_stb_q <= end_stb_d;
        end
    end

    assign active  = (timer_q != '0);
    assign warn    = active && (32'(timer_q) <= WARN_FRAMES);
    assign end_stb = end_stb_q;

endmodule

`default_nettype wire

// File: rtl/pickup_tracker.sv
// +----------------------------------------------------------------------+
// | pickup_tracker: tile lookup, eat strobes, score, pellets, power mode |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pickup_tracker
    import pickup_tracker_pkg::*;
#(
    parameter int MAP_W        = 28,
    parameter int MAP_H        = 31,
    parameter int MAP_RD_LAT   = 1,
    parameter int PELLET_TOTAL = 244,
    parameter int SCORE_W      = 20,
    parameter int POWER_FRAMES = 360,
    parameter int WARN_FRAMES  = 120
) (
    input  logic                              vga_pix_clk,
    input  logic                              rst,
    input  logic                              level_rst,
    input  logic                              frame_stb,
    input  logic                              pos_valid,
    input  logic [$clog2(MAP_W)-1:0]          pos_x,
    input  logic [$clog2(MAP_H)-1:0]          pos_y,
    output logic                              busy,
    output logic [$clog2(MAP_W*MAP_H)-1:0]    map_rd_addr,
    input  logic [3:0]                        map_tile,
    output logic                              map_wr_en,
    output logic [$clog2(MAP_W*MAP_H)-1:0]    map_wr_addr,
    output logic [3:0]                        map_wr_data,
    output logic                              ate_candy_stb,
    output logic                              ate_power_cookie_stb,
    output logic                              level_clear_stb,
    output logic [SCORE_W-1:0]                score,
    output logic [$clog2(PELLET_TOTAL+1)-1:0] pellets_left,
    output logic                              power_active,
    output logic                              power_warn,
    output logic                              power_end_stb
);

    localparam int A_W = $clog2(MAP_W * MAP_H);
    localparam int P_W = $clog2(PELLET_TOTAL + 1);
    localparam int C_W = (MAP_RD_LAT > 1) ? $clog2(MAP_RD_LAT) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    pickup_state_t      state_q, state_d;
    logic [A_W-1:0]     addr_q, addr_d;
    logic [C_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic               candy_q, candy_d;
    logic               cookie_q, cookie_d;
    logic               clear_q, clear_d;
    logic               wr_en_q, wr_en_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [P_W-1:0]     pellets_q, pellets_d;

    logic               pos_ok;
    logic               is_candy;
    logic               is_cookie;
    logic               reload;
    logic [SCORE_W:0]   points;
    logic [SCORE_W:0]   score_sum;

    assign pos_ok    = (32'(pos_x) < MAP_W) && (32'(pos_y) < MAP_H);
    assign is_candy  = (map_tile == candy_tile);
    assign is_cookie = (map_tile == cookie_tile);
    assign points    = is_cookie ? (SCORE_W+1)'(COOKIE_POINTS) : (SCORE_W+1)'(CANDY_POINTS);
    assign score_sum = {1'b0, score_q} + points;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_cnt_d  = rd_cnt_q;
        candy_d   = 1'b0;
        cookie_d  = 1'b0;
        clear_d   = 1'b0;
        wr_en_d   = 1'b0;
        score_d   = score_q;
        pellets_d = pellets_q;
        reload    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pos_valid && pos_ok) begin
                    addr_d   = A_W'(pos_y) * A_W'(MAP_W) + A_W'(pos_x);
                    rd_cnt_d = '0;
                    state_d  = RD;
                end
            end
            RD: begin
                if (rd_cnt_q == C_W'(MAP_RD_LAT - 1)) begin
                    state_d = EAT;
                end else begin
                    rd_cnt_d = rd_cnt_q + C_W'(1);
                end
            end
            EAT: begin
                state_d = IDLE;
                if (is_candy || is_cookie) begin
                    candy_d  = is_candy;
                    cookie_d = is_cookie;
                    reload   = is_cookie;
                    wr_en_d  = 1'b1;
                    score_d  = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
                    // Eats after the level is cleared still score but leave the count at zero.
                    if (pellets_q != '0) begin
                        pellets_d = pellets_q - P_W'(1);
                        clear_d   = (pellets_q == P_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (level_rst) begin
            state_d   = IDLE;
            candy_d   = 1'b0;
            cookie_d  = 1'b0;
            clear_d   = 1'b0;
            wr_en_d   = 1'b0;
            reload    = 1'b0;
            score_d   = score_q;
            pellets_d = P_W'(PELLET_TOTAL);
        end
    end

    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_cnt_q  <= '0;
            candy_q   <= 1'b0;
            cookie_q  <= 1'b0;
            clear_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            score_q   <= '0;
            pellets_q <= P_W'(PELLET_TOTAL);
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_cnt_q  <= rd_cnt_d;
            candy_q   <= candy_d;
            cookie_q  <= cookie_d;
            clear_q   <= clear_d;
            wr_en_q   <= wr_en_d;
            score_q   <= score_d;
            pellets_q <= pellets_d;
        end
    end

    power_timer #(
        .POWER_FRAMES (POWER_FRAMES),
        .WARN_FRAMES  (WARN_FRAMES)
    ) u_power_timer (
        .vga_pix_clk (vga_pix_clk),
        .rst         (rst),
        .clear       (level_rst),
        .reload      (reload),
        .frame_stb   (frame_stb),
        .active      (power_active),
        .warn        (power_warn),
        .end_stb     (power_end_stb)
    );

    // addr_q only moves when a new lookup is accepted, so it is still the eaten tile in the write cycle.
    assign busy                 = (state_q != IDLE);
    assign map_rd_addr          = addr_q;
    assign map_wr_addr          = addr_q;
    assign map_wr_en            = wr_en_q;
    assign map_wr_data          = empty_tile;
    assign ate_candy_stb        = candy_q;
    assign ate_power_cookie_stb = cookie_q;
    assign level_clear_stb      = clear_q;
    assign score                = score_q;
    assign pellets_left         = pellets_q;

endmodule

`default_nettype wire

// File: tb/tb_pickup_tracker.sv
// +----------------------------------------------------------------------+
// | tb_pickup_tracker: directed vector bench for pickup_tracker          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pickup_tracker;
    import pickup_tracker_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       pv [2];
    logic [4:0] px [2];
    logic [4:0] py [2];
    logic       fs [2];
    logic       lr [2];

    int checks = 0;
    int errors = 0;

    // dut0: defaults
    logic        busy0, wr_en0, candy0, cookie0, clear0, act0, warn0, end0;
    logic [9:0]  rd_addr0, wr_addr0;
    logic [3:0]  wr_data0, tile0;
    logic [19:0] score0;
    logic [7:0]  pel0;
    // dut1: two pellets, two-cycle RAM
    logic        busy1, wr_en1, candy1, cookie1, clear1, act1, warn1, end1;
    logic [9:0]  rd_addr1, wr_addr1;
    logic [3:0]  wr_data1, tile1, tile1_p1;
    logic [19:0] score1;
    logic [1:0]  pel1;
    // dut2: 6-bit score, shares dut0 stimulus and map data
    logic        busy2, wr_en2, candy2, cookie2, clear2, act2, warn2, end2;
    logic [9:0]  rd_addr2, wr_addr2;
    logic [3:0]  wr_data2;
    logic [5:0]  score2;
    logic [7:0]  pel2;

    logic [3:0] ram0 [0:867];
    logic [3:0] ram1 [0:867];

    pickup_tracker u_dut0 (
        .vga_pix_clk(clk), .rst(rst), .level_rst(lr[0]), .frame_stb(fs[0]),
        .pos_valid(pv[0]), .pos_x(px[0]), .pos_y(py[0]), .busy(busy0),
        .map_rd_addr(rd_addr0), .map_tile(tile0), .map_wr_en(wr_en0),
        .map_wr_addr(wr_addr0), .map_wr_data(wr_data0), .ate_candy_stb(candy0),
        .ate_power_cookie_stb(cookie0), .level_clear_stb(clear0), .score(score0),
        .pellets_left(pel0), .power_active(act0), .power_warn(warn0), .power_end_stb(end0)
    );

    pickup_tracker #(.MAP_RD_LAT(2), .PELLET_TOTAL(2)) u_dut1 (
        .vga_pix_clk(clk), .rst(rst), .level_rst(lr[1]), .frame_stb(fs[1]),
        .pos_valid(pv[1]), .pos_x(px[1]), .pos_y(py[1]), .busy(busy1),
        .map_rd_addr(rd_addr1), .map_tile(tile1), .map_wr_en(wr_en1),
        .map_wr_addr(wr_addr1), .map_wr_data(wr_data1), .ate_candy_stb(candy1),
        .ate_power_cookie_stb(cookie1), .level_clear_stb(clear1), .score(score1),
        .pellets_left(pel1), .power_active(act1), .power_warn(warn1), .power_end_stb(end1)
    );

    pickup_tracker #(.SCORE_W(6)) u_dut2 (
        .vga_pix_clk(clk), .rst(rst), .level_rst(lr[0]), .frame_stb(fs[0]),
        .pos_valid(pv[0]), .pos_x(px[0]), .pos_y(py[0]), .busy(busy2),
        .map_rd_addr(rd_addr2), .map_tile(tile0), .map_wr_en(wr_en2),
        .map_wr_addr(wr_addr2), .map_wr_data(wr_data2), .ate_candy_stb(candy2),
        .ate_power_cookie_stb(cookie2), .level_clear_stb(clear2), .score(score2),
        .pellets_left(pel2), .power_active(act2), .power_warn(warn2), .power_end_stb(end2)
    );

    function automatic logic [3:0] init_tile(input int d, input int i);
        if (d == 0) begin
            case (i)
                29, 30, 35, 36, 37: return candy_tile;
                31, 32, 34:         return cookie_tile;
                61:                 return 4'h3;
                default:            return empty_tile;
            endcase
        end else begin
            case (i)
                29, 31:  return candy_tile;
                30:      return cookie_tile;
                default: return empty_tile;
            endcase
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 868; i++) ram0[i] <= init_tile(0, i);
        end else if (wr_en0) begin
            ram0[wr_addr0] <= wr_data0;
        end
        tile0 <= ram0[rd_addr0];
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 868; i++) ram1[i] <= init_tile(1, i);
        end else if (wr_en1) begin
            ram1[wr_addr1] <= wr_data1;
        end
        tile1_p1 <= ram1[rd_addr1];
        tile1    <= tile1_p1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the result cycle (pos_valid cycle + LAT + 2).
    task automatic do_lookup(input int d, input int x, input int y, input bit exp_busy);
        int lat;
        lat   = (d == 0) ? 1 : 2;
        px[d] = 5'(x);
        py[d] = 5'(y);
        pv[d] = 1'b1;
        @(negedge clk);
        pv[d] = 1'b0;
        chk($sformatf("busy_c1_d%0d", d), (d == 0) ? busy0 : busy1, exp_busy);
        if (exp_busy)
            chk($sformatf("rd_addr_d%0d", d), (d == 0) ? 32'(rd_addr0) : 32'(rd_addr1), 32'(y * 28 + x));
        repeat (lat + 1) @(negedge clk);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            fs[0] = 1'b1;
            @(negedge clk);
            fs[0] = 1'b0;
            @(negedge clk);
        end
    endtask

    typedef struct {
        int x; int y; bit busy; bit candy; bit cookie; bit wr;
        int waddr; int score; int pel; bit act; int score6;
    } vec_t;

    vec_t vt [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1, 1, 1, 1, 0, 1, 29, 10, 243, 0, 10};
        vt[1] = '{1, 1, 1, 0, 0, 0, 0, 10, 243, 0, 10};
        vt[2] = '{2, 1, 1, 1, 0, 1, 30, 20, 242, 0, 20};
        vt[3] = '{5, 2, 1, 0, 0, 0, 0, 20, 242, 0, 20};
        vt[4] = '{3, 1, 1, 0, 1, 1, 31, 70, 241, 1, 63};
        vt[5] = '{28, 0, 0, 0, 0, 0, 0, 70, 241, 1, 63};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            pv[d] = 1'b0; px[d] = '0; py[d] = '0; fs[d] = 1'b0; lr[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_strobes", {candy0, cookie0, clear0, end0}, 0);
        chk("rst_wr_en", wr_en0, 0);
        chk("rst_score", score0, 0);
        chk("rst_pellets", pel0, 244);
        chk("rst_power", {act0, warn0}, 0);
        chk("rst_addrs", {rd_addr0, wr_addr0}, 0);
        chk("rst_pellets_d1", pel1, 2);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_lookup(0, vt[i].x, vt[i].y, vt[i].busy);
            chk($sformatf("v%0d_candy", i), candy0, vt[i].candy);
            chk($sformatf("v%0d_cookie", i), cookie0, vt[i].cookie);
            chk($sformatf("v%0d_wr_en", i), wr_en0, vt[i].wr);
            if (vt[i].wr) begin
                chk($sformatf("v%0d_wr_addr", i), wr_addr0, vt[i].waddr);
                chk($sformatf("v%0d_wr_data", i), wr_data0, empty_tile);
            end
            chk($sformatf("v%0d_score", i), score0, vt[i].score);
            chk($sformatf("v%0d_pellets", i), pel0, vt[i].pel);
            chk($sformatf("v%0d_busy", i), busy0, 0);
            chk($sformatf("v%0d_active", i), act0, vt[i].act);
            chk($sformatf("v%0d_score6", i), score2, vt[i].score6);
            @(negedge clk);
            chk($sformatf("v%0d_stb_clear", i), {candy0, cookie0, wr_en0}, 0);
        end

        // Power countdown from 360
        frames(239);
        chk("pw_warn_121", warn0, 0);
        chk("pw_active_121", act0, 1);
        frames(1);
        chk("pw_warn_120", warn0, 1);
        frames(119);
        chk("pw_active_1", act0, 1);
        chk("pw_end_early", end0, 0);
        fs[0] = 1'b1;
        @(negedge clk);
        fs[0] = 1'b0;
        chk("pw_end_stb", end0, 1);
        chk("pw_inactive", {act0, warn0}, 0);
        @(negedge clk);
        chk("pw_end_one_cycle", end0, 0);

        // Cookie reload racing frame_stb at timer=5
        do_lookup(0, 4, 1, 1);
        chk("ck2_cookie", cookie0, 1);
        chk("ck2_score", score0, 120);
        chk("ck2_pellets", pel0, 240);
        frames(355);
        chk("ck2_warn_t5", warn0, 1);
        px[0] = 5'd6; py[0] = 5'd1; pv[0] = 1'b1;
        @(negedge clk);
        pv[0] = 1'b0;
        @(negedge clk);
        fs[0] = 1'b1;
        @(negedge clk);
        fs[0] = 1'b0;
        chk("race_cookie", cookie0, 1);
        chk("race_power", {act0, warn0, end0}, 3'b100);
        chk("race_score", score0, 170);
        chk("race_pellets", pel0, 239);
        frames(239);
        chk("race_warn_121", warn0, 0);
        frames(1);
        chk("race_warn_120", warn0, 1);

        // level_rst in the EAT cycle
        px[0] = 5'd7; py[0] = 5'd1; pv[0] = 1'b1;
        @(negedge clk);
        pv[0] = 1'b0;
        @(negedge clk);
        lr[0] = 1'b1;
        @(negedge clk);
        lr[0] = 1'b0;
        chk("lr_no_stb", {candy0, cookie0, wr_en0}, 0);
        chk("lr_pellets", pel0, 244);
        chk("lr_score_kept", score0, 170);
        chk("lr_power", {act0, end0, busy0}, 0);
        chk("lr_tile_kept", ram0[35], candy_tile);
        chk("lr_score6_kept", score2, 63);

        // pos_valid while busy is ignored
        px[0] = 5'd8; py[0] = 5'd1; pv[0] = 1'b1;
        @(negedge clk);
        px[0] = 5'd9;
        @(negedge clk);
        pv[0] = 1'b0;
        @(negedge clk);
        chk("bz_candy", candy0, 1);
        chk("bz_wr_addr", wr_addr0, 36);
        chk("bz_score", score0, 180);
        repeat (3) @(negedge clk);
        chk("bz_idle", {busy0, candy0}, 0);
        chk("bz_score_after", score0, 180);
        chk("bz_pellets", pel0, 243);
        chk("bz_tile_36", ram0[36], empty_tile);
        chk("bz_tile_37", ram0[37], candy_tile);

        // Two-pellet level with two-cycle RAM latency
        do_lookup(1, 1, 1, 1);
        chk("p2_candy", candy1, 1);
        chk("p2_score1", score1, 10);
        chk("p2_pel1", pel1, 1);
        chk("p2_clear_early", clear1, 0);
        @(negedge clk);
        do_lookup(1, 2, 1, 1);
        chk("p2_cookie", cookie1, 1);
        chk("p2_clear", clear1, 1);
        chk("p2_pel0", pel1, 0);
        chk("p2_score2", score1, 60);
        chk("p2_active", act1, 1);
        @(negedge clk);
        chk("p2_clear_once", {clear1, cookie1}, 0);
        do_lookup(1, 3, 1, 1);
        chk("p2_candy3", candy1, 1);
        chk("p2_score3", score1, 70);
        chk("p2_pel_stays", pel1, 0);
        chk("p2_no_clear", clear1, 0);
        @(negedge clk);
        do_lookup(1, 1, 1, 1);
        chk("p2_repeat", {candy1, cookie1, wr_en1}, 0);
        chk("p2_repeat_score", score1, 70);

        // Full reset clears the score
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_score", score0, 0);
        chk("rst2_pellets", pel0, 244);
        chk("rst2_score_d1", score1, 0);
        chk("rst2_pellets_d1", pel1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
